rr_grant_sequencer: RTL and testbench

- Round-robin arbiter that shares one resource among N requesters, using a rotating-priority "first set bit" search.
- Registers the grant and holds it until the owner releases, drops its request, or exceeds a maximum hold time.
- Sits between per-lane request lines and a shared resource port; downstream logic consumes both the one-hot grant and the encoded position.

---
 rtl/rr_grant_sequencer_if.sv | 28 ++
 rtl/rr_grant_sequencer.sv | 110 +++++++++++
 tb/tb_rr_grant_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_grant_sequencer_if.sv
// Request/grant bundle between the requesting lanes and the round-robin arbiter.
// The master side drives requests and release pulses; the slave side returns the grant.
interface rr_grant_sequencer_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_pos;
  logic         gnt_valid;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_pos,
    input  gnt_valid
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_pos,
    output gnt_valid
  );
endinterface

// File: rtl/rr_grant_sequencer.sv
// Rotating-priority arbiter: registers a one-hot grant and holds it until the owner
// releases, drops its request or reaches the hold limit, then hands off on the same edge.
module rr_grant_sequencer #(
  parameter int N        = 8,
  parameter int W        = 3,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  rr_grant_sequencer_if.slave   bus
);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            r_state;
  logic [N-1:0]      r_gnt;
  logic [W-1:0]      r_pos;
  logic [W-1:0]      r_last;
  logic              r_valid;
  logic [HOLD_W-1:0] r_hold;

  logic              w_dropped;
  logic              w_timeout;
  logic              w_release;
  logic [N-1:0]      w_cand;
  logic [W-1:0]      w_base;
  logic [W-1:0]      w_idx;
  logic [W-1:0]      w_win;
  logic              w_found;
  logic [N-1:0]      w_win_onehot;

  assign w_dropped = (r_state == ST_GRANT) && !bus.req[r_pos];
  assign w_timeout = (r_hold == HOLD_LAST);
  assign w_release = (r_state == ST_GRANT) && (bus.done || w_dropped || w_timeout);

  // A holder that dropped its request is removed; done/timeout keep it eligible at lowest priority.
  always_comb begin
    w_cand = bus.req;
    if (w_dropped) begin
      w_cand[r_pos] = 1'b0;
    end
  end

  assign w_base = (r_state == ST_GRANT) ? r_pos : r_last;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = w_base + W'(k + 1);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_win;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_pos   <= '0;
      r_last  <= W'(N - 1);
      r_valid <= 1'b0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_GRANT;
            r_gnt   <= w_win_onehot;
            r_pos   <= w_win;
            r_valid <= 1'b1;
            r_hold  <= '0;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_last <= r_pos;
            r_hold <= '0;
            if (w_found) begin
              r_gnt <= w_win_onehot;
              r_pos <= w_win;
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= '0;
              r_valid <= 1'b0;
            end
          end else if (r_hold != HOLD_LAST) begin
            r_hold <= r_hold + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_pos   = r_pos;
  assign bus.gnt_valid = r_valid;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Self-checking bench for rr_grant_sequencer: directed scenarios plus a randomized run,
// all compared against a cycle-level behavioural arbiter model.
module tb_rr_grant_sequencer;

  localparam int N        = 8;
  localparam int W        = 3;
  localparam int MAX_HOLD = 16;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  // Model state: owner index (-1 when idle), last released owner, cycles held, retained position.
  int mOwner;
  int mLast;
  int mHeld;
  int mPos;

  rr_grant_sequencer_if #(.N(N), .W(W)) bus ();

  rr_grant_sequencer #(
    .N(N), .W(W), .MAX_HOLD(MAX_HOLD), .HOLD_W(5)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int search(input logic [N-1:0] cand, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (cand[i]) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mOwner = -1;
    mLast  = N - 1;
    mHeld  = 0;
    mPos   = 0;
  endtask

  task automatic modelStep(input logic [N-1:0] r, input logic d);
    int            w;
    logic          dropped;
    logic [N-1:0]  cand;
    if (mOwner < 0) begin
      w = search(r, mLast);
      if (w >= 0) begin
        mOwner = w;
        mPos   = w;
        mHeld  = 1;
      end
    end else begin
      dropped = !r[mOwner];
      if (d || dropped || mHeld == MAX_HOLD) begin
        cand = r;
        if (dropped) cand[mOwner] = 1'b0;
        mLast = mOwner;
        w = search(cand, mLast);
        if (w >= 0) begin
          mOwner = w;
          mPos   = w;
          mHeld  = 1;
        end else begin
          mOwner = -1;
        end
      end else begin
        mHeld++;
      end
    end
  endtask

  task automatic compareModel();
    logic [N-1:0] expGnt;
    expGnt = (mOwner < 0) ? '0 : (N'(1) << mOwner);
    checkOutput("gnt", 32'(bus.gnt), 32'(expGnt));
    checkOutput("gnt_pos", 32'(bus.gnt_pos), 32'(mPos));
    checkOutput("gnt_valid", 32'(bus.gnt_valid), 32'(mOwner >= 0));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare just after it.
  task automatic applyStimulus(input logic [N-1:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    modelStep(r, d);
    @(posedge clk);
    #1;
    compareModel();
  endtask

  task automatic doReset();
    bus.req  = '0;
    bus.done = 1'b0;
    resetn   = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    checkOutput("reset_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("reset_valid", 32'(bus.gnt_valid), 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.req  = '0;
    bus.done = 1'b0;
    resetn   = 1'b0;
    modelReset();

    // Single requester grant and release back to idle.
    doReset();
    applyStimulus(8'h10, 1'b0);
    checkOutput("single_gnt", 32'(bus.gnt), 32'h10);
    checkOutput("single_pos", 32'(bus.gnt_pos), 32'd4);
    applyStimulus(8'h00, 1'b1);
    checkOutput("single_idle_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("single_idle_valid", 32'(bus.gnt_valid), 32'h0);
    checkOutput("single_idle_pos", 32'(bus.gnt_pos), 32'd4);
    applyStimulus(8'h00, 1'b1);

    // Full rotation with done every cycle: no idle bubble between grants.
    doReset();
    applyStimulus(8'hFF, 1'b0);
    checkOutput("rot_first", 32'(bus.gnt_pos), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(8'hFF, 1'b1);
      checkOutput("rot_pos", 32'(bus.gnt_pos), 32'(i % 8));
      checkOutput("rot_valid", 32'(bus.gnt_valid), 32'h1);
    end

    // Timeout alternation between two requesters.
    doReset();
    for (int c = 0; c < 48; c++) begin
      applyStimulus(8'h05, 1'b0);
      checkOutput("timeout_pos", 32'(bus.gnt_pos), ((c / 16) % 2 == 0) ? 32'd0 : 32'd2);
    end
    for (int c = 0; c < 40; c++) begin
      applyStimulus(8'h01, 1'b0);
      checkOutput("timeout_solo", 32'(bus.gnt), 32'h01);
    end

    // Request drop handoff, then drop to idle.
    doReset();
    applyStimulus(8'h08, 1'b0);
    applyStimulus(8'h88, 1'b0);
    checkOutput("drop_owner", 32'(bus.gnt_pos), 32'd3);
    applyStimulus(8'h80, 1'b0);
    checkOutput("drop_gnt", 32'(bus.gnt), 32'h80);
    checkOutput("drop_pos", 32'(bus.gnt_pos), 32'd7);
    applyStimulus(8'h00, 1'b0);
    checkOutput("drop_idle", 32'(bus.gnt_valid), 32'h0);

    // No preemption, then wrap-around search after done.
    applyStimulus(8'h40, 1'b0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(8'h41, 1'b0);
      checkOutput("nopreempt_pos", 32'(bus.gnt_pos), 32'd6);
    end
    applyStimulus(8'h41, 1'b1);
    checkOutput("wrap_pos", 32'(bus.gnt_pos), 32'd0);
    checkOutput("wrap_gnt", 32'(bus.gnt), 32'h01);

    // Asynchronous reset mid-grant, observed between clock edges.
    doReset();
    applyStimulus(8'h04, 1'b0);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("midgrant_gnt", 32'(bus.gnt), 32'h04);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("async_pos", 32'(bus.gnt_pos), 32'd0);
    checkOutput("async_valid", 32'(bus.gnt_valid), 32'h0);
    modelReset();
    #1;
    resetn = 1'b1;
    applyStimulus(8'hFF, 1'b0);
    checkOutput("post_reset_gnt", 32'(bus.gnt), 32'h01);

    // Randomized traffic with sticky requests and occasional done pulses.
    doReset();
    begin
      logic [N-1:0] r;
      logic         d;
      r = '0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(3) == 0) r = N'($urandom);
        if ($urandom_range(9) == 0) r = '0;
        d = ($urandom_range(4) == 0);
        applyStimulus(r, d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
